// File: rtl/sap_pkg.sv
// sap_pkg: shared definitions for the SAP core and its boot sequencer.
//   WORD_W       : data word width of the core and RAM
//   boot_state_t : boot sequencer FSM encoding (also visible on its state port)
package sap_pkg;

   localparam int WORD_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_FLUSH  = 3'd2,
      ST_RUN    = 3'd3,
      ST_HALTED = 3'd4,
      ST_ERROR  = 3'd5
   } boot_state_t;

endpackage

// File: rtl/boot_wr_stage.sv
// boot_wr_stage: registered RAM write stage of the boot sequencer.
// A write requested in cycle n appears on ram_we/ram_addr/ram_wdata in
// cycle n+1 for one cycle. With BOOT_CHECKSUM_EN defined it also keeps
// the 16-bit running sum of every word it writes.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   sum_clr, sum       : (BOOT_CHECKSUM_EN only) clear / running sum
//   wr_en/addr/data    : write request from the FSM
//   ram_we/addr/wdata  : registered RAM write port (address zero-extended)
module boot_wr_stage
   import sap_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
`ifdef BOOT_CHECKSUM_EN
   input  logic              sum_clr,
   output logic [WORD_W-1:0] sum,
`endif
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WORD_W-1:0] wr_data,
   output logic              ram_we,
   output logic [WORD_W-1:0] ram_addr,
   output logic [WORD_W-1:0] ram_wdata
);

   always_ff @(posedge clk) begin
      if (rst) begin
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
      end else begin
         ram_we <= wr_en;
         if (wr_en) begin
            ram_addr  <= WORD_W'(wr_addr);
            ram_wdata <= wr_data;
         end
      end
   end

`ifdef BOOT_CHECKSUM_EN
   // Sum of written words only; the checksum word itself is never written.
   always_ff @(posedge clk) begin
      if (rst || sum_clr) sum <= '0;
      else if (wr_en)     sum <= sum + wr_data;
   end
`endif

endmodule

// File: rtl/boot_sequencer.sv
// boot_sequencer: power-on / reload sequencer for the 16-bit SAP core.
// Holds the core in reset, owns the RAM write port while streaming an
// image from the loader (valid/ready), then releases the core and waits
// for halt, after which a reload may be requested.
// Optional feature: define BOOT_CHECKSUM_EN to treat the ld_last word as a
// checksum of the image (not written); mismatch or overflow -> ERROR.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   ld_start                      : (re)load request (IDLE/HALTED/ERROR)
//   ld_valid/ld_data/ld_last/ld_ready : loader stream
//   cpu_halt                      : core halted (level)
//   cpu_rst, cpu_run              : core reset / clock enable
//   mem_sel                       : 1 = sequencer owns RAM port
//   ram_we/ram_addr/ram_wdata     : RAM write port
//   state, words, err             : debug state, words loaded, sticky error
module boot_sequencer
   import sap_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld_start,
   input  logic              ld_valid,
   input  logic [WORD_W-1:0] ld_data,
   input  logic              ld_last,
   output logic              ld_ready,
   input  logic              cpu_halt,
   output logic              cpu_rst,
   output logic              cpu_run,
   output logic              mem_sel,
   output logic              ram_we,
   output logic [WORD_W-1:0] ram_addr,
   output logic [WORD_W-1:0] ram_wdata,
   output logic [2:0]        state,
   output logic [ADDR_W:0]   words,
   output logic              err
);

   localparam logic [ADDR_W-1:0] PTR_MAX = '1;

   boot_state_t       state_q, state_d;
   logic [ADDR_W:0]   words_q;
   logic              err_q;
   logic              hs, at_max, start, wr_en, set_err;
`ifdef BOOT_CHECKSUM_EN
   logic [WORD_W-1:0] sum;
`endif

   // The low bits of the word count double as the write pointer; the top
   // bit flags a completely filled image.
   assign ld_ready = (state_q == ST_LOAD) && !words_q[ADDR_W];
   assign hs       = ld_valid && ld_ready;
   assign at_max   = (words_q[ADDR_W-1:0] == PTR_MAX);
   assign start    = (state_d == ST_LOAD) && (state_q != ST_LOAD);

   always_comb begin
      state_d = state_q;
      wr_en   = 1'b0;
      set_err = 1'b0;
      case (state_q)
         ST_IDLE:   if (ld_start) state_d = ST_LOAD;
         ST_LOAD: begin
            if (hs) begin
`ifdef BOOT_CHECKSUM_EN
               wr_en = !ld_last;
               if (ld_last) begin
                  if (sum == ld_data) state_d = ST_FLUSH;
                  else begin
                     state_d = ST_ERROR;
                     set_err = 1'b1;
                  end
               end else if (at_max) begin
                  state_d = ST_ERROR;
                  set_err = 1'b1;
               end
`else
               wr_en = 1'b1;
               if (ld_last) state_d = ST_FLUSH;
               else if (at_max) begin
                  // truncated image: still release the core
                  state_d = ST_FLUSH;
                  set_err = 1'b1;
               end
`endif
            end
         end
         ST_FLUSH:  state_d = ST_RUN;
         ST_RUN:    if (cpu_halt) state_d = ST_HALTED;
         ST_HALTED: if (ld_start) state_d = ST_LOAD;
         ST_ERROR:  if (ld_start) state_d = ST_LOAD;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Core controls are decoded from the next state so they change in the
   // same cycle the state register does.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         words_q <= '0;
         err_q   <= 1'b0;
         cpu_rst <= 1'b1;
         cpu_run <= 1'b0;
         mem_sel <= 1'b1;
      end else begin
         state_q <= state_d;
         if (start)      words_q <= '0;
         else if (wr_en) words_q <= words_q + 1'b1;
         if (start)        err_q <= 1'b0;
         else if (set_err) err_q <= 1'b1;
         cpu_rst <= (state_d inside {ST_IDLE, ST_LOAD, ST_FLUSH, ST_ERROR});
         cpu_run <= (state_d == ST_RUN);
         mem_sel <= !(state_d inside {ST_RUN, ST_HALTED});
      end
   end

   boot_wr_stage #(.ADDR_W(ADDR_W)) u_wr (
      .clk       (clk),
      .rst       (rst),
`ifdef BOOT_CHECKSUM_EN
      .sum_clr   (start),
      .sum       (sum),
`endif
      .wr_en     (wr_en),
      .wr_addr   (words_q[ADDR_W-1:0]),
      .wr_data   (ld_data),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata)
   );

   assign state = state_q;
   assign words = words_q;
   assign err   = err_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// tb_boot_sequencer: directed bench for boot_sequencer. u_dut uses
// ADDR_W=8; u_small uses ADDR_W=2 for the overflow case. Checksum cases
// are built when BOOT_CHECKSUM_EN is defined.
module tb_boot_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ld_start = 1'b0, ld_start2 = 1'b0;
   logic        ld_valid = 1'b0, ld_last = 1'b0, cpu_halt = 1'b0;
   logic [15:0] ld_data = '0;

   logic        ld_ready, cpu_rst, cpu_run, mem_sel, ram_we, err;
   logic [15:0] ram_addr, ram_wdata;
   logic [2:0]  state;
   logic [8:0]  words;

   logic        ld_ready2, cpu_rst2, cpu_run2, mem_sel2, ram_we2, err2;
   logic [15:0] ram_addr2, ram_wdata2;
   logic [2:0]  state2;
   logic [2:0]  words2;

   int total = 0, bad = 0;
   logic [15:0] wa[$], wd[$], wa2[$], wd2[$];

   boot_sequencer #(.ADDR_W(8)) u_dut (
      .clk(clk), .rst(rst), .ld_start(ld_start), .ld_valid(ld_valid),
      .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
      .cpu_halt(cpu_halt), .cpu_rst(cpu_rst), .cpu_run(cpu_run),
      .mem_sel(mem_sel), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .state(state), .words(words), .err(err)
   );

   boot_sequencer #(.ADDR_W(2)) u_small (
      .clk(clk), .rst(rst), .ld_start(ld_start2), .ld_valid(ld_valid),
      .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready2),
      .cpu_halt(cpu_halt), .cpu_rst(cpu_rst2), .cpu_run(cpu_run2),
      .mem_sel(mem_sel2), .ram_we(ram_we2), .ram_addr(ram_addr2),
      .ram_wdata(ram_wdata2), .state(state2), .words(words2), .err(err2)
   );

   always #5 clk = ~clk;

   // write monitors
   always @(negedge clk) begin
      if (ram_we === 1'b1) begin
         wa.push_back(ram_addr);
         wd.push_back(ram_wdata);
      end
      if (ram_we2 === 1'b1) begin
         wa2.push_back(ram_addr2);
         wd2.push_back(ram_wdata2);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // present one word and wait (bounded) until it is accepted
   task automatic send(input logic [15:0] d, input logic l);
      int n = 0;
      ld_valid = 1'b1;
      ld_data  = d;
      ld_last  = l;
      while (!ld_ready && n < 20) begin
         tick();
         n++;
      end
      chk("rdy_wait", {31'd0, ld_ready}, 32'd1);
      tick();
   endtask

   task automatic chk_wr(input int idx, input logic [15:0] a, input logic [15:0] d);
      if (idx < wa.size()) begin
         chk($sformatf("wr_addr[%0d]", idx), {16'd0, wa[idx]}, {16'd0, a});
         chk($sformatf("wr_data[%0d]", idx), {16'd0, wd[idx]}, {16'd0, d});
      end else begin
         chk($sformatf("wr_missing[%0d]", idx), idx, 32'hFFFF_FFFF);
      end
   endtask

   task automatic halt_and_start();
      cpu_halt = 1'b1; tick(); cpu_halt = 1'b0;
      ld_start = 1'b1; tick(); ld_start = 1'b0;
   endtask

   initial begin
      int base, k;
      logic h;
      tick(); tick();
      // reset state
      chk("rst_state",   state,     0);
      chk("rst_cpu_rst", cpu_rst,   1);
      chk("rst_cpu_run", cpu_run,   0);
      chk("rst_mem_sel", mem_sel,   1);
      chk("rst_ram_we",  ram_we,    0);
      chk("rst_ram_addr",ram_addr,  0);
      chk("rst_ld_ready",ld_ready,  0);
      chk("rst_words",   words,     0);
      chk("rst_err",     err,       0);
      rst = 1'b0;
      tick();
      chk("idle_hold", state, 0);

`ifdef BOOT_CHECKSUM_EN
      // good checksum
      ld_start = 1'b1; tick(); ld_start = 1'b0;
      send(16'h0001, 1'b0);
      send(16'h0002, 1'b0);
      send(16'h0003, 1'b1);
      ld_valid = 1'b0; ld_last = 1'b0;
      chk("cs_flush", state, 2);
      tick();
      chk("cs_run",   state, 3);
      chk("cs_words", words, 2);
      chk("cs_err",   err,   0);
      chk("cs_nwr",   wa.size(), 2);
      chk_wr(0, 16'h0000, 16'h0001);
      chk_wr(1, 16'h0001, 16'h0002);
      // bad checksum
      halt_and_start();
      send(16'h0001, 1'b0);
      send(16'h0002, 1'b0);
      send(16'h0004, 1'b1);
      ld_valid = 1'b0; ld_last = 1'b0;
      chk("cs_err_state", state, 5);
      chk("cs_err_flag",  err,   1);
      tick();
      chk("cs_err_hold",  state, 5);
      chk("cs_err_rst",   cpu_rst, 1);
      chk("cs_err_msel",  mem_sel, 1);
      chk("cs_err_words", words, 2);
      chk("cs_err_nwr",   wa.size(), 4);
`else
      // basic load
      ld_start = 1'b1; tick(); ld_start = 1'b0;
      chk("load_state", state, 1);
      chk("load_ready", ld_ready, 1);
      chk("load_cpu_rst", cpu_rst, 1);
      send(16'h1111, 1'b0);
      chk("wl_we",   ram_we, 1);
      chk("wl_addr", ram_addr, 16'h0000);
      chk("wl_data", ram_wdata, 16'h1111);
      send(16'h2222, 1'b0);
      chk("b2b_we",   ram_we, 1);
      chk("b2b_addr", ram_addr, 16'h0001);
      send(16'h3333, 1'b1);
      ld_valid = 1'b0; ld_last = 1'b0;
      chk("flush_state", state, 2);
      chk("flush_we",    ram_we, 1);
      chk("flush_addr",  ram_addr, 16'h0002);
      chk("flush_rst",   cpu_rst, 1);
      tick();
      chk("run_state", state, 3);
      chk("run_rst",   cpu_rst, 0);
      chk("run_run",   cpu_run, 1);
      chk("run_msel",  mem_sel, 0);
      chk("run_we",    ram_we, 0);
      chk("run_words", words, 3);
      chk("run_err",   err, 0);
      chk("basic_nwr", wa.size(), 3);
      chk_wr(0, 16'h0000, 16'h1111);
      chk_wr(1, 16'h0001, 16'h2222);
      chk_wr(2, 16'h0002, 16'h3333);

      // ld_start ignored in RUN
      ld_start = 1'b1; tick(); ld_start = 1'b0;
      chk("run_ign_start", state, 3);

      // halt then reload a 2-word image
      cpu_halt = 1'b1; tick(); cpu_halt = 1'b0;
      chk("halt_run",   cpu_run, 0);
      chk("halt_state", state, 4);
      chk("halt_rst",   cpu_rst, 0);
      chk("halt_msel",  mem_sel, 0);
      tick();
      ld_start = 1'b1; tick(); ld_start = 1'b0;
      chk("reld_state", state, 1);
      chk("reld_rst",   cpu_rst, 1);
      chk("reld_msel",  mem_sel, 1);
      chk("reld_words", words, 0);
      base = wa.size();
      send(16'hABCD, 1'b0);
      send(16'h1234, 1'b1);
      ld_valid = 1'b0; ld_last = 1'b0;
      tick();
      chk("reld_run",   state, 3);
      chk("reld_words2", words, 2);
      chk("reld_nwr",   wa.size(), base + 2);
      chk_wr(base,     16'h0000, 16'hABCD);
      chk_wr(base + 1, 16'h0001, 16'h1234);

      // backpressure: toggling valid, a 5-cycle gap, valid held after end
      halt_and_start();
      base = wa.size();
      send(16'hB000, 1'b0); ld_valid = 1'b0; tick();
      send(16'hB001, 1'b0); ld_valid = 1'b0; tick();
      send(16'hB002, 1'b0); ld_valid = 1'b0; repeat (5) tick();
      send(16'hB003, 1'b0); ld_valid = 1'b0; tick();
      send(16'hB004, 1'b1);
      ld_last = 1'b0; ld_data = 16'hDEAD;
      repeat (3) tick();
      ld_valid = 1'b0;
      chk("bp_state", state, 3);
      chk("bp_words", words, 5);
      chk("bp_nwr",   wa.size(), base + 5);
      for (int i = 0; i < 5; i++)
         chk_wr(base + i, 16'(i), 16'hB000 + 16'(i));

      // reset in the middle of a load
      halt_and_start();
      base = wa.size();
      send(16'h5555, 1'b0);
      send(16'h6666, 1'b0);
      ld_valid = 1'b0;
      rst = 1'b1; tick(); rst = 1'b0;
      chk("mid_state", state, 0);
      chk("mid_we",    ram_we, 0);
      chk("mid_words", words, 0);
      chk("mid_rst",   cpu_rst, 1);
      chk("mid_nwr",   wa.size(), base + 2);

      // overflow on the ADDR_W=2 instance: 5 words offered, no ld_last
      ld_start2 = 1'b1; tick(); ld_start2 = 1'b0;
      k = 0;
      ld_valid = 1'b1; ld_last = 1'b0; ld_data = 16'hA000;
      repeat (8) begin
         h = ld_ready2;
         tick();
         if (h) begin
            k++;
            ld_data = 16'hA000 + 16'(k);
         end
      end
      ld_valid = 1'b0;
      chk("ovf_accepted", k, 4);
      chk("ovf_ready",    ld_ready2, 0);
      chk("ovf_err",      err2, 1);
      chk("ovf_state",    state2, 3);
      chk("ovf_words",    words2, 4);
      chk("ovf_cpu_rst",  cpu_rst2, 0);
      chk("ovf_nwr",      wa2.size(), 4);
      for (int i = 0; i < 4 && i < wa2.size(); i++) begin
         chk("ovf_addr", wa2[i], 16'(i));
         chk("ovf_data", wd2[i], 16'hA000 + 16'(i));
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule
